// File: rtl/core_ex_lsu.sv
// core_ex_lsu: execute-stage load/store unit. Runs one data-memory transaction
// at a time and returns extended load data or a fault to writeback.
//
// Handshake rules: a request transfers on any rising edge where its valid and
// ready are both high. Once mem_req_valid rises, it and every mem_req_* field
// hold steady until mem_req_ready is seen. mem_rsp_valid is a one-cycle
// qualifier with no back-pressure, and the LSU samples it only in RESP.
// lsu_req_ready is high only in IDLE and is masked while lsu_flush is high.
module core_ex_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_is_store,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [4:0]      lsu_rd,
  input  logic            lsu_flush,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_we,
  output logic [3:0]      mem_req_wstrb,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  input  logic            mem_rsp_err,
  output logic            lsu_done,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            lsu_exc,
  output logic [1:0]      lsu_exc_cause,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_DONE = 3'd3,
    S_EXC  = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_LD_MIS   = 2'd0;
  localparam logic [1:0] CAUSE_ST_MIS   = 2'd1;
  localparam logic [1:0] CAUSE_LD_FAULT = 2'd2;
  localparam logic [1:0] CAUSE_ST_FAULT = 2'd3;

  state_t state_q, state_d;
  logic   kill_q, kill_d;

  // Latched request descriptor.
  logic       is_store_q, is_store_d;
  logic [1:0] size_q, size_d;
  logic       unsigned_q, unsigned_d;
  logic [1:0] ofs_q, ofs_d;
  logic [4:0] rd_q, rd_d;

  // Registered memory request outputs.
  logic            mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0] mem_req_addr_q, mem_req_addr_d;
  logic            mem_req_we_q, mem_req_we_d;
  logic [3:0]      mem_req_wstrb_q, mem_req_wstrb_d;
  logic [XLEN-1:0] mem_req_wdata_q, mem_req_wdata_d;

  // Registered completion outputs.
  logic            lsu_done_q, lsu_done_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            lsu_exc_q, lsu_exc_d;
  logic [1:0]      lsu_exc_cause_q, lsu_exc_cause_d;

  // Request-side decode of the incoming op.
  logic            req_misaligned;
  logic [3:0]      req_wstrb;
  logic [XLEN-1:0] req_wdata;

  // Response-side extraction of the addressed bytes.
  logic [XLEN-1:0] rsp_shifted;
  logic [XLEN-1:0] rsp_ext;
  logic            rsp_killed;

  // Decode alignment, store byte lanes and lane-replicated store data.
  always_comb begin
    req_misaligned = 1'b0;
    req_wstrb      = 4'b1111;
    req_wdata      = lsu_wdata;
    case (lsu_size)
      2'b00: begin
        req_wstrb = 4'b0001 << lsu_addr[1:0];
        req_wdata = {(XLEN/8){lsu_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = lsu_addr[0];
        req_wstrb      = 4'b0011 << lsu_addr[1:0];
        req_wdata      = {(XLEN/16){lsu_wdata[15:0]}};
      end
      default: begin
        req_misaligned = (lsu_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Shift the addressed bytes down to bit 0 and sign/zero-extend by size.
  always_comb begin
    rsp_shifted = mem_rsp_rdata >> {ofs_q, 3'b000};
    rsp_ext     = mem_rsp_rdata;
    case (size_q)
      2'b00:   rsp_ext = {{(XLEN-8){~unsigned_q & rsp_shifted[7]}}, rsp_shifted[7:0]};
      2'b01:   rsp_ext = {{(XLEN-16){~unsigned_q & rsp_shifted[15]}}, rsp_shifted[15:0]};
      default: rsp_ext = mem_rsp_rdata;
    endcase
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    is_store_d      = is_store_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    ofs_d           = ofs_q;
    rd_d            = rd_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_wstrb_d = mem_req_wstrb_q;
    mem_req_wdata_d = mem_req_wdata_q;
    lsu_done_d      = 1'b0;
    wb_we_d         = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    lsu_exc_d       = 1'b0;
    lsu_exc_cause_d = lsu_exc_cause_q;
    // A flush in the same cycle as the response still kills the op.
    rsp_killed      = kill_q | lsu_flush;

    // Flush only marks the op; the memory handshake runs to completion.
    if (state_q != S_IDLE && lsu_flush) begin
      kill_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (lsu_req_valid && !lsu_flush) begin
          is_store_d = lsu_is_store;
          size_d     = lsu_size;
          unsigned_d = lsu_unsigned;
          ofs_d      = lsu_addr[1:0];
          rd_d       = lsu_rd;
          if (req_misaligned) begin
            // Misaligned ops complete with a fault and never reach memory.
            state_d         = S_EXC;
            lsu_done_d      = 1'b1;
            lsu_exc_d       = 1'b1;
            lsu_exc_cause_d = lsu_is_store ? CAUSE_ST_MIS : CAUSE_LD_MIS;
            wb_rd_d         = lsu_rd;
            wb_data_d       = '0;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = {lsu_addr[XLEN-1:2], 2'b00};
            mem_req_we_d    = lsu_is_store;
            mem_req_wstrb_d = lsu_is_store ? req_wstrb : 4'b0000;
            mem_req_wdata_d = lsu_is_store ? req_wdata : '0;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rsp_valid) begin
          state_d         = S_DONE;
          lsu_done_d      = ~rsp_killed;
          lsu_exc_d       = ~rsp_killed & mem_rsp_err;
          lsu_exc_cause_d = is_store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
          wb_we_d         = ~rsp_killed & ~mem_rsp_err & ~is_store_q & (rd_q != 5'd0);
          wb_rd_d         = rd_q;
          wb_data_d       = (!is_store_q && !mem_rsp_err) ? rsp_ext : '0;
        end
      end
      S_DONE, S_EXC: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      kill_q          <= 1'b0;
      is_store_q      <= 1'b0;
      size_q          <= 2'b00;
      unsigned_q      <= 1'b0;
      ofs_q           <= 2'b00;
      rd_q            <= 5'd0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_we_q    <= 1'b0;
      mem_req_wstrb_q <= 4'b0000;
      mem_req_wdata_q <= '0;
      lsu_done_q      <= 1'b0;
      wb_we_q         <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_data_q       <= '0;
      lsu_exc_q       <= 1'b0;
      lsu_exc_cause_q <= 2'd0;
    end else begin
      state_q         <= state_d;
      kill_q          <= kill_d;
      is_store_q      <= is_store_d;
      size_q          <= size_d;
      unsigned_q      <= unsigned_d;
      ofs_q           <= ofs_d;
      rd_q            <= rd_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_wstrb_q <= mem_req_wstrb_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      lsu_done_q      <= lsu_done_d;
      wb_we_q         <= wb_we_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      lsu_exc_q       <= lsu_exc_d;
      lsu_exc_cause_q <= lsu_exc_cause_d;
    end
  end

  assign lsu_req_ready = (state_q == S_IDLE) && !lsu_flush;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_wstrb = mem_req_wstrb_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign lsu_done      = lsu_done_q;
  assign wb_we         = wb_we_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign lsu_exc       = lsu_exc_q;
  assign lsu_exc_cause = lsu_exc_cause_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_core_ex_lsu.sv
// tb_core_ex_lsu: directed and randomized checks of core_ex_lsu against a
// behavioural memory/extension model kept in the bench.
module tb_core_ex_lsu;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic            lsu_is_store;
  logic [1:0]      lsu_size;
  logic            lsu_unsigned;
  logic [XLEN-1:0] lsu_addr;
  logic [XLEN-1:0] lsu_wdata;
  logic [4:0]      lsu_rd;
  logic            lsu_flush;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_we;
  logic [3:0]      mem_req_wstrb;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            mem_rsp_err;
  logic            lsu_done;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            lsu_exc;
  logic [1:0]      lsu_exc_cause;
  logic [2:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  core_ex_lsu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_is_store(lsu_is_store), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rd(lsu_rd), .lsu_flush(lsu_flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .lsu_done(lsu_done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_exc(lsu_exc), .lsu_exc_cause(lsu_exc_cause), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: load result from the raw word, by byte offset and size.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input int ofs, input logic [31:0] rdata);
    longint v;
    int nbits;
    if (sz == 2'b00) nbits = 8;
    else if (sz == 2'b01) nbits = 16;
    else nbits = 32;
    v = longint'(rdata) / (longint'(1) << (8 * ofs));
    if (nbits == 32) return rdata;
    v = v % (longint'(1) << nbits);
    if (!uns && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_strb(input logic st, input logic [1:0] sz, input int ofs);
    if (!st) return 0;
    if (sz == 2'b00) return 32'(1 << ofs);
    if (sz == 2'b01) return 32'(3 << ofs);
    return 15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return (wd % 256) * 32'h0101_0101;
    if (sz == 2'b01) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] sz, input int ofs);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (ofs % 2) != 0;
    return ofs != 0;
  endfunction

  // Driver + memory responder for one complete op. Inputs change and outputs
  // are sampled on falling edges.
  task automatic run_op(input string name, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] rdata, input logic err,
                        input int req_wait, input int rsp_wait, input logic flush_resp);
    int ofs;
    logic mis;
    logic killed;
    logic [31:0] exp_strb;
    logic [31:0] exp_wd;
    logic [31:0] got;
    ofs = int'(addr % 4);
    mis = ref_misaligned(sz, ofs);
    killed = flush_resp && (rsp_wait > 0);
    exp_strb = ref_strb(st, sz, ofs);
    exp_wd = ref_wdata(sz, wd);
    @(negedge clk);
    check({name, ".ready_idle"}, 32'(lsu_req_ready), 1);
    lsu_req_valid = 1'b1;
    lsu_is_store  = st;
    lsu_size      = sz;
    lsu_unsigned  = uns;
    lsu_addr      = addr;
    lsu_wdata     = wd;
    lsu_rd        = rd;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    lsu_addr      = $urandom;
    lsu_wdata     = $urandom;
    if (mis) begin
      check({name, ".mis_done"}, 32'(lsu_done), 1);
      check({name, ".mis_exc"}, 32'(lsu_exc), 1);
      check({name, ".mis_cause"}, 32'(lsu_exc_cause), st ? 1 : 0);
      check({name, ".mis_wb_we"}, 32'(wb_we), 0);
      check({name, ".mis_no_req"}, 32'(mem_req_valid), 0);
      @(negedge clk);
      check({name, ".mis_ready"}, 32'(lsu_req_ready), 1);
      check({name, ".mis_done_low"}, 32'(lsu_done), 0);
      check({name, ".mis_no_req2"}, 32'(mem_req_valid), 0);
      return;
    end
    for (int i = 0; i <= req_wait; i++) begin
      check({name, ".req_valid"}, 32'(mem_req_valid), 1);
      check({name, ".req_addr"}, mem_req_addr, addr - 32'(ofs));
      check({name, ".req_we"}, 32'(mem_req_we), 32'(st));
      check({name, ".req_wstrb"}, 32'(mem_req_wstrb), exp_strb);
      if (st) check({name, ".req_wdata"}, mem_req_wdata, exp_wd);
      check({name, ".busy_ready"}, 32'(lsu_req_ready), 0);
      if (i == req_wait) begin
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
      end else begin
        // Stray response strobes outside RESP must be ignored.
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_rdata = $urandom;
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    check({name, ".req_dropped"}, 32'(mem_req_valid), 0);
    for (int i = 0; i < rsp_wait; i++) begin
      lsu_flush = flush_resp && (i == 0);
      @(negedge clk);
      lsu_flush = 1'b0;
      check({name, ".resp_wait_done"}, 32'(lsu_done), 0);
      check({name, ".resp_wait_ready"}, 32'(lsu_req_ready), 0);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    mem_rsp_err   = err;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    check({name, ".done"}, 32'(lsu_done), killed ? 0 : 1);
    check({name, ".exc"}, 32'(lsu_exc), (!killed && err) ? 1 : 0);
    check({name, ".wb_we"}, 32'(wb_we), (!killed && !err && !st && rd != 0) ? 1 : 0);
    if (!killed && err) check({name, ".cause"}, 32'(lsu_exc_cause), st ? 3 : 2);
    if (!killed && !err && !st) begin
      exp_q.push_back(ref_load(sz, uns, ofs, rdata));
      got = exp_q.pop_front();
      check({name, ".wb_data"}, wb_data, got);
      check({name, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    end
    @(negedge clk);
    check({name, ".done_pulse"}, 32'(lsu_done), 0);
    check({name, ".ready_again"}, 32'(lsu_req_ready), 1);
  endtask

  initial begin
    logic st;
    logic [1:0] sz;
    int rw;
    int pw;
    logic fl;
    rst_n         = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_is_store  = 1'b0;
    lsu_size      = 2'b00;
    lsu_unsigned  = 1'b0;
    lsu_addr      = '0;
    lsu_wdata     = '0;
    lsu_rd        = '0;
    lsu_flush     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    #12;
    check("reset.ready", 32'(lsu_req_ready), 1);
    check("reset.req_valid", 32'(mem_req_valid), 0);
    check("reset.req_addr", mem_req_addr, 0);
    check("reset.wstrb", 32'(mem_req_wstrb), 0);
    check("reset.done", 32'(lsu_done), 0);
    check("reset.wb_data", wb_data, 0);
    check("reset.exc", 32'(lsu_exc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op("lb_signed", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd7, 32'h80FF_1234, 1'b0, 0, 0, 1'b0);
    run_op("sh_upper", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 5'd3, 32'h0, 1'b0, 0, 0, 1'b0);
    run_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd4, 32'h0, 1'b0, 0, 0, 1'b0);
    run_op("sw_mis", 1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h1, 5'd4, 32'h0, 1'b0, 0, 0, 1'b0);
    run_op("lh_mis", 1'b0, 2'b01, 1'b1, 32'h0000_3003, 32'h0, 5'd4, 32'h0, 1'b0, 0, 0, 1'b0);
    run_op("lw_fault", 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd9, 32'hDEAD_BEEF, 1'b1, 5, 2, 1'b0);
    run_op("sb_fault", 1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'h0000_00A5, 5'd9, 32'h0, 1'b1, 1, 0, 1'b0);
    run_op("lhu_flush", 1'b0, 2'b01, 1'b1, 32'h0000_5002, 32'h0, 5'd5, 32'h8001_7FFF, 1'b0, 0, 1, 1'b1);
    run_op("after_flush", 1'b0, 2'b01, 1'b1, 32'h0000_5002, 32'h0, 5'd5, 32'h8001_7FFF, 1'b0, 0, 0, 1'b0);
    run_op("lw_rd0", 1'b0, 2'b11, 1'b0, 32'h0000_6000, 32'h0, 5'd0, 32'h1234_5678, 1'b0, 0, 0, 1'b0);
    run_op("lb_unsigned", 1'b0, 2'b00, 1'b1, 32'h0000_7001, 32'h0, 5'd31, 32'h0000_F000, 1'b0, 0, 0, 1'b0);
    run_op("sb_lane2", 1'b1, 2'b00, 1'b0, 32'h0000_7002, 32'h1234_5677, 5'd1, 32'h0, 1'b0, 2, 1, 1'b0);

    // A request presented with flush in IDLE is refused.
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_flush     = 1'b1;
    lsu_is_store  = 1'b0;
    lsu_size      = 2'b10;
    lsu_addr      = 32'h0000_8000;
    #1;
    check("idle_flush.ready_masked", 32'(lsu_req_ready), 0);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    lsu_flush     = 1'b0;
    check("idle_flush.no_req", 32'(mem_req_valid), 0);
    check("idle_flush.no_done", 32'(lsu_done), 0);
    #1;
    check("idle_flush.ready_back", 32'(lsu_req_ready), 1);

    // Reset while the request is waiting in REQ.
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_is_store  = 1'b1;
    lsu_size      = 2'b10;
    lsu_addr      = 32'h0000_9004;
    lsu_wdata     = 32'hCAFE_F00D;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    check("rst_mid.req_valid_before", 32'(mem_req_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.req_valid", 32'(mem_req_valid), 0);
    check("rst_mid.req_addr", mem_req_addr, 0);
    check("rst_mid.we", 32'(mem_req_we), 0);
    check("rst_mid.wdata", mem_req_wdata, 0);
    check("rst_mid.ready", 32'(lsu_req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized ops.
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      rw = $urandom_range(0, 3);
      pw = $urandom_range(0, 3);
      fl = ($urandom_range(0, 5) == 0);
      if (fl && pw == 0) pw = 1;
      run_op("rand", st, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 7) == 0),
             rw, pw, fl);
    end

    check("scoreboard.empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
